// File: rtl/sdram_ctrl_pkg.sv
// Shared definitions for the SDRAM controller front end: internal wb_port bus widths
// and the port arbiter state encoding.
package sdram_ctrl_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 16;
  localparam int SEL_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Index width that stays at least one bit wide for single-entry vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request strictly after `last`,
// wrapping around, as both a one-hot vector and an index.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last) + i) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller request port among wb_port
// instances; the grant is held across read-burst gaps.
//
// state | meaning
// IDLE  | no owner, arbitrate among requesting ports
// BUSY  | owner's access is active, its signals drive the controller
// HOLD  | owner dropped acc, grant kept until it re-requests or the counter expires
module sdram_port_arbiter
  import sdram_ctrl_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                      sdram_clk,
  input  logic                      sdram_rst_n,
  input  logic [ADR_W*NPORTS-1:0]   port_adr_i,
  input  logic [DAT_W*NPORTS-1:0]   port_dat_i,
  input  logic [SEL_W*NPORTS-1:0]   port_sel_i,
  input  logic [NPORTS-1:0]         port_acc_i,
  input  logic [NPORTS-1:0]         port_we_i,
  output logic [NPORTS-1:0]         port_ack_o,
  output logic [ADR_W-1:0]          adr_o,
  output logic [DAT_W-1:0]          dat_o,
  output logic [SEL_W-1:0]          sel_o,
  output logic                      acc_o,
  output logic                      we_o,
  input  logic                      ack_i,
  output logic [NPORTS-1:0]         grant_o
);

  localparam int IW = idx_w(NPORTS);
  localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES);
  localparam logic [IW-1:0] LAST_RST = IW'(NPORTS - 1);

  logic [1:0]        state;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     last;
  logic [CW-1:0]     cnt;
  logic [NPORTS-1:0] grant_q;

  logic [NPORTS-1:0] pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              owner_acc;
  logic              active;

  rr_pick #(
    .N  (NPORTS),
    .IW (IW)
  ) u_pick (
    .req  (port_acc_i),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign active = (state == ST_BUSY) || (state == ST_HOLD);

  always_comb begin
    owner_acc = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (owner == IW'(p)) owner_acc = port_acc_i[p];
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst_n) begin
      state   <= ST_IDLE;
      owner   <= '0;
      last    <= LAST_RST;
      cnt     <= '0;
      grant_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            owner   <= pick_idx;
            last    <= pick_idx;
            grant_q <= pick_gnt;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!owner_acc) begin
            if (HOLD_CYCLES == 0) begin
              state <= ST_IDLE;
            end else begin
              cnt   <= HOLD_LD;
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Re-request resumes the same owner; other ports wait for the counter.
          if (owner_acc) begin
            state <= ST_BUSY;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt <= CW'(1)) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Muxes stay combinational: wb_port swaps to the low half in the ack cycle.
  always_comb begin
    adr_o      = '0;
    dat_o      = '0;
    sel_o      = '0;
    acc_o      = 1'b0;
    we_o       = 1'b0;
    port_ack_o = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (active && owner == IW'(p)) begin
        adr_o         = port_adr_i[p*ADR_W +: ADR_W];
        dat_o         = port_dat_i[p*DAT_W +: DAT_W];
        sel_o         = port_sel_i[p*SEL_W +: SEL_W];
        acc_o         = port_acc_i[p];
        we_o          = port_we_i[p];
        port_ack_o[p] = ack_i;
      end
    end
  end

  assign grant_o = active ? grant_q : '0;

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Round-robin arbiter that shares the single internal request port of the SDRAM controller among NPORTS wb_port instances, all in the sdram_clk domain. Grants one port at a time, muxes its address/data/select/strobe/write-enable onto the controller, and routes ack back only to the owner. Holds the grant through the gap between the two back-to-back read bursts and the read-data tail, so another port cannot interleave a refill or a write.

## Interface
- NPORTS, 2: number of wb_port requesters (≥1).
- HOLD_CYCLES, 8: cycles the grant is kept after the owner drops its access request; 0 means release immediately.
- sdram_clk  in  1  clock; every signal is synchronous to it.
- sdram_rst_n  in  1  reset, synchronous, active-low.
- port_adr_i  in  32*NPORTS  per-port address, port p at [32p+31:32p].
- port_dat_i  in  16*NPORTS  per-port write data.
- port_sel_i  in  2*NPORTS  per-port byte selects.
- port_acc_i  in  NPORTS  per-port access request.
- port_we_i  in  NPORTS  per-port write enable.
- port_ack_o  out  NPORTS  ack to each port; only the owner's bit can be high.
- adr_o  out  32  to controller.
- dat_o  out  16  to controller.
- sel_o  out  2  to controller.
- acc_o  out  1  to controller.
- we_o  out  1  to controller.
- ack_i  in  1  from controller.
- grant_o  out  NPORTS  one-hot current owner, all-zero when idle.

## Operation
- Registered state: IDLE, BUSY, HOLD; owner index; last-owner pointer; hold counter of width clog2(HOLD_CYCLES+1).
- IDLE:
  - If any port_acc_i is high, pick the first requester scanning from last+1 upward, wrapping at NPORTS.
  - Register it as owner and as last; go to BUSY.
  - With no requests, stay in IDLE.
- BUSY: owner's port_acc_i low → load counter with HOLD_CYCLES and go to HOLD; if HOLD_CYCLES=0, go directly to IDLE.
- HOLD:
  - Owner's port_acc_i high → BUSY. Owner keeps its grant and is not re-arbitrated.
  - Otherwise decrement the counter; at 0 go to IDLE.
  - Other ports' requests are ignored while in HOLD.
- Output mux (combinational from the owner register and the owner's inputs):
  - adr_o, dat_o and sel_o follow the owner's inputs; idle value 0.
  - acc_o = owner's acc in BUSY/HOLD, else 0.
  - we_o = owner's we in BUSY/HOLD, else 0.
  - port_ack_o[owner] = ack_i in BUSY/HOLD. Every other bit is 0.
  - ack_i arriving in IDLE is dropped.
- The muxes must stay combinational: wb_port switches dat_o/sel_o/adr_o to the low half in the same cycle ack_i is seen.
- The controller's read data and address echo go directly to every port and do not pass through this block.

## Timing
- Request-to-grant latency: 1 cycle.
  - Port acc rises in cycle N while IDLE → grant_o and acc_o high in N+1.
- Back-to-back owners: the earliest new grant is 1 cycle after IDLE is re-entered.
- Release after the owner's acc falls in cycle N:
  - IDLE at N+1+HOLD_CYCLES.
  - A new grant at N+2+HOLD_CYCLES at the earliest.
- Owner acc re-rising in HOLD: acc_o follows it in the same cycle (combinational path).
- Reset (sdram_rst_n=0 at a clock edge), including mid-transaction:
  - Return to IDLE, owner=0, last=NPORTS-1, counter=0.
  - Outputs: grant_o=0, acc_o=0, we_o=0, port_ack_o=0, adr_o/dat_o/sel_o=0.
- Fairness: with all ports requesting continuously, each port is granted exactly once per NPORTS grants.
- NPORTS=1: arbitration degenerates to a pass-through, but the state machine and hold behaviour are unchanged.

## Structure
- Shared package sdram_ctrl_pkg holds:
  - the state encoding (IDLE/BUSY/HOLD);
  - the wb_port internal-bus widths (ADR_W=32, DAT_W=16, SEL_W=2).
- One sub-module: rr_pick, a combinational round-robin priority picker (request vector + last pointer → one-hot plus index). It is reusable for future arbiters.

## Test plan
- Single port write: port0 acc=1, we=1, adr=0x100 in cycle 0 → grant_o=01 and acc_o=1 in cycle 1.
  - ack_i pulse in cycle 4 → port_ack_o=01 in cycle 4 only.
  - Port drops acc → IDLE 9 cycles later (HOLD_CYCLES=8).
- Simultaneous requests after reset: ports 0 and 1 both request → port 0 granted first, port 1 granted after port 0's hold expires.
  - Repeat with both requesting again → port 1 is not granted twice in a row.
- Read burst gap: owner drops acc after ack, then re-raises it 3 cycles later; port 1 requests throughout → grant stays with owner and acc_o re-rises with no IDLE cycle.
  - Port 1 is granted only after HOLD expires.
- Ack isolation: inject ack_i while IDLE → port_ack_o=0. Inject ack_i while port 1 owns → port_ack_o=10.
- Reset mid-BUSY: assert sdram_rst_n=0 for 1 cycle while port 0 owns → next cycle acc_o=0 and grant_o=0.
  - Port 0's still-high request is re-granted 1 cycle after reset release.
- HOLD_CYCLES=0 build: owner drops acc → IDLE next cycle, and a waiting port is granted the cycle after.
